cache_refill_ctrl: RTL

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

---
 rtl/cache_refill_ctrl_pkg.sv | 19 +
 rtl/cache_refill_ctrl_array.sv | 48 ++++
 rtl/cache_refill_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cache_refill_ctrl_pkg.sv
// rtl/cache_refill_ctrl_pkg.sv - shared geometry constants and FSM state encoding for the refill controller
package cache_refill_ctrl_pkg;
  localparam int LINES  = 8;
  localparam int WORDS  = 4;
  localparam int TAG_W  = 5;
  localparam int IDX_W  = 3;
  localparam int OFF_W  = 2;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_BURST,
    WB_WAIT,
    RF_BURST,
    RF_WAIT,
    RESPOND
  } state_e;
endpackage

// File: rtl/cache_refill_ctrl_array.sv
// rtl/cache_refill_ctrl_array.sv - tag/valid/dirty/data storage with one write port and combinational read
module cache_line_array
  import cache_refill_ctrl_pkg::*;
#(
  parameter int NLINES = LINES,
  parameter int NWORDS = WORDS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [OFF_W-1:0] word_sel_i,
  input  logic             wr_en_i,
  input  logic [31:0]      wr_data_i,
  input  logic             meta_we_i,
  input  logic             meta_valid_i,
  input  logic             meta_dirty_i,
  input  logic [TAG_W-1:0] meta_tag_i,
  output logic [TAG_W-1:0] rd_tag_o,
  output logic             rd_valid_o,
  output logic             rd_dirty_o,
  output logic [31:0]      rd_word_o
);
  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [31:0]       data_q [NLINES][NWORDS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[idx_i] <= meta_valid_i;
      dirty_q[idx_i] <= meta_dirty_i;
    end
  end

  // Tags and data carry no reset; the valid bits alone decide whether they mean anything.
  always_ff @(posedge clk_i) begin
    if (meta_we_i) tag_q[idx_i] <= meta_tag_i;
    if (wr_en_i)   data_q[idx_i][word_sel_i] <= wr_data_i;
  end

  assign rd_tag_o   = tag_q[idx_i];
  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_word_o  = data_q[idx_i][word_sel_i];
endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - direct-mapped write-back cache controller with burst refill and write-back
module cache_refill_ctrl #(
  parameter int LINES = cache_refill_ctrl_pkg::LINES,
  parameter int WORDS = cache_refill_ctrl_pkg::WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [9:0]  cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [9:0]  mem_address,
  output logic [31:0] mem_data_out,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_value,
  input  logic        mem_done
);
  import cache_refill_ctrl_pkg::*;

  state_e           state_q;
  logic [OFF_W-1:0] beat_q;
  logic [9:0]       addr_q;
  logic             we_q;
  logic [31:0]      wdata_q;

  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_off;
  assign a_tag = addr_q[9:5];
  assign a_idx = addr_q[4:2];
  assign a_off = addr_q[1:0];

  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid, rd_dirty;
  logic [31:0]      rd_word;
  logic [OFF_W-1:0] word_sel;
  logic             wr_en, meta_we, meta_valid, meta_dirty;
  logic [31:0]      wr_data;
  logic [TAG_W-1:0] meta_tag;

  logic hit, last_beat;
  assign hit       = rd_valid && (rd_tag == a_tag);
  assign last_beat = (beat_q == OFF_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req) begin
          addr_q  <= cpu_addr;
          we_q    <= cpu_we;
          wdata_q <= cpu_wdata;
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          beat_q <= '0;
          if (hit)                        state_q <= RESPOND;
          else if (rd_valid && rd_dirty)  state_q <= WB_BURST;
          else                            state_q <= RF_BURST;
        end
        WB_BURST: begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) state_q <= WB_WAIT;
        end
        WB_WAIT: if (mem_done) begin
          beat_q  <= '0;
          state_q <= RF_BURST;
        end
        RF_BURST: begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) state_q <= RF_WAIT;
        end
        RF_WAIT: if (mem_done) state_q <= RESPOND;
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // During a write-back the array is read at the old tag, so the victim address comes from rd_tag.
  always_comb begin
    word_sel   = (state_q == WB_BURST || state_q == RF_BURST) ? beat_q : a_off;
    wr_en      = 1'b0;
    wr_data    = wdata_q;
    meta_we    = 1'b0;
    meta_valid = rd_valid;
    meta_dirty = 1'b0;
    meta_tag   = rd_tag;
    case (state_q)
      RF_BURST: begin
        wr_en   = 1'b1;
        wr_data = mem_read_value;
      end
      WB_WAIT: meta_we = mem_done;
      RF_WAIT: begin
        meta_we    = mem_done;
        meta_valid = 1'b1;
        meta_tag   = a_tag;
      end
      RESPOND: if (we_q) begin
        wr_en      = 1'b1;
        meta_we    = 1'b1;
        meta_valid = 1'b1;
        meta_dirty = 1'b1;
        meta_tag   = a_tag;
      end
      default: ;
    endcase
  end

  cache_line_array #(
    .NLINES (LINES),
    .NWORDS (WORDS)
  ) u_array (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .idx_i        (a_idx),
    .word_sel_i   (word_sel),
    .wr_en_i      (wr_en),
    .wr_data_i    (wr_data),
    .meta_we_i    (meta_we),
    .meta_valid_i (meta_valid),
    .meta_dirty_i (meta_dirty),
    .meta_tag_i   (meta_tag),
    .rd_tag_o     (rd_tag),
    .rd_valid_o   (rd_valid),
    .rd_dirty_o   (rd_dirty),
    .rd_word_o    (rd_word)
  );

  assign mem_write    = (state_q == WB_BURST);
  assign mem_read     = (state_q == RF_BURST);
  assign mem_address  = mem_write ? {rd_tag, a_idx, beat_q} :
                        mem_read  ? {a_tag, a_idx, beat_q} : '0;
  assign mem_data_out = mem_write ? rd_word : '0;
  assign cpu_ready    = (state_q == RESPOND);
  assign cpu_rdata    = (cpu_ready && !we_q) ? rd_word : '0;
endmodule
